// File: rtl/reorder_buffer.sv
// In-order retirement buffer: entries are allocated in program order at rename, marked
// complete by tag from EXE/MEM, and retired oldest-first, one per cycle, toward RRAT/free list.
module reorder_buffer #(
    parameter int DEPTH  = 16,
    parameter int TAG_W  = 4,
    parameter int PHYS_W = 6
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              flush,

    input  logic              alloc_valid,
    input  logic [4:0]        alloc_arch_dst,
    input  logic [PHYS_W-1:0] alloc_new_phys,
    input  logic [PHYS_W-1:0] alloc_old_phys,
    input  logic              alloc_regwrite,
    input  logic [31:0]       alloc_pc,
    output logic              alloc_ready,
    output logic [TAG_W-1:0]  alloc_tag,

    input  logic              cmpl_exe_valid,
    input  logic [TAG_W-1:0]  cmpl_exe_tag,
    input  logic              cmpl_mem_valid,
    input  logic [TAG_W-1:0]  cmpl_mem_tag,

    output logic              retire_valid,
    output logic [4:0]        retire_arch_dst,
    output logic [PHYS_W-1:0] retire_new_phys,
    output logic [PHYS_W-1:0] retire_old_phys,
    output logic              retire_regwrite,
    output logic [31:0]       retire_pc,

    output logic [TAG_W:0]    count,
    output logic              empty
);

    localparam logic [TAG_W:0] FULL_CNT = (TAG_W + 1)'(DEPTH);

    logic [TAG_W-1:0]  head_q;
    logic [TAG_W-1:0]  tail_q;
    logic [TAG_W:0]    count_q;

    logic [DEPTH-1:0]  valid_q;
    logic [DEPTH-1:0]  done_q;
    logic [DEPTH-1:0]  valid_d;
    logic [DEPTH-1:0]  done_d;

    logic [4:0]        arch_q  [DEPTH];
    logic [PHYS_W-1:0] new_q   [DEPTH];
    logic [PHYS_W-1:0] old_q   [DEPTH];
    logic              regw_q  [DEPTH];
    logic [31:0]       pc_q    [DEPTH];

    logic              alloc_fire;
    logic              retire_fire;

    assign alloc_ready = (count_q != FULL_CNT);
    assign alloc_tag   = tail_q;
    assign count       = count_q;
    assign empty       = (count_q == '0);

    assign alloc_fire  = alloc_valid && alloc_ready && !flush;
    // Retire looks only at registered flags, so a completion needs one edge to become visible.
    assign retire_fire = valid_q[head_q] && done_q[head_q] && !flush;

    always_comb begin
        valid_d = valid_q;
        done_d  = done_q;
        if (cmpl_exe_valid && valid_q[cmpl_exe_tag]) begin
            done_d[cmpl_exe_tag] = 1'b1;
        end
        if (cmpl_mem_valid && valid_q[cmpl_mem_tag]) begin
            done_d[cmpl_mem_tag] = 1'b1;
        end
        if (retire_fire) begin
            valid_d[head_q] = 1'b0;
            done_d[head_q]  = 1'b0;
        end
        // Tail can only coincide with head when empty (head invalid) or full (alloc blocked).
        if (alloc_fire) begin
            valid_d[tail_q] = 1'b1;
            done_d[tail_q]  = 1'b0;
        end
        if (flush) begin
            valid_d = '0;
            done_d  = '0;
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            head_q          <= '0;
            tail_q          <= '0;
            count_q         <= '0;
            valid_q         <= '0;
            done_q          <= '0;
            retire_valid    <= 1'b0;
            retire_arch_dst <= '0;
            retire_new_phys <= '0;
            retire_old_phys <= '0;
            retire_regwrite <= 1'b0;
            retire_pc       <= '0;
        end else begin
            valid_q <= valid_d;
            done_q  <= done_d;
            if (flush) begin
                head_q       <= '0;
                tail_q       <= '0;
                count_q      <= '0;
                retire_valid <= 1'b0;
            end else begin
                retire_valid <= retire_fire;
                if (alloc_fire) begin
                    tail_q <= tail_q + 1'b1;
                end
                if (retire_fire) begin
                    head_q          <= head_q + 1'b1;
                    retire_arch_dst <= arch_q[head_q];
                    retire_new_phys <= new_q[head_q];
                    retire_old_phys <= old_q[head_q];
                    retire_regwrite <= regw_q[head_q] && (arch_q[head_q] != 5'd0);
                    retire_pc       <= pc_q[head_q];
                end
                case ({alloc_fire, retire_fire})
                    2'b10:   count_q <= count_q + 1'b1;
                    2'b01:   count_q <= count_q - 1'b1;
                    default: count_q <= count_q;
                endcase
            end
        end
    end

    // Payload is qualified by valid_q, so it needs no reset.
    always_ff @(posedge CLK) begin
        if (alloc_fire) begin
            arch_q[tail_q] <= alloc_arch_dst;
            new_q[tail_q]  <= alloc_new_phys;
            old_q[tail_q]  <= alloc_old_phys;
            regw_q[tail_q] <= alloc_regwrite;
            pc_q[tail_q]   <= alloc_pc;
        end
    end

endmodule

// File: tb/tb_reorder_buffer.sv
// Self-checking bench for reorder_buffer: directed test-plan sequences followed by random
// traffic, checked every cycle against a program-order queue model.
module tb_reorder_buffer;

    localparam int DEPTH  = 16;
    localparam int TAG_W  = 4;
    localparam int PHYS_W = 6;

    logic              CLK;
    logic              RESET;
    logic              flush;
    logic              alloc_valid;
    logic [4:0]        alloc_arch_dst;
    logic [PHYS_W-1:0] alloc_new_phys;
    logic [PHYS_W-1:0] alloc_old_phys;
    logic              alloc_regwrite;
    logic [31:0]       alloc_pc;
    logic              alloc_ready;
    logic [TAG_W-1:0]  alloc_tag;
    logic              cmpl_exe_valid;
    logic [TAG_W-1:0]  cmpl_exe_tag;
    logic              cmpl_mem_valid;
    logic [TAG_W-1:0]  cmpl_mem_tag;
    logic              retire_valid;
    logic [4:0]        retire_arch_dst;
    logic [PHYS_W-1:0] retire_new_phys;
    logic [PHYS_W-1:0] retire_old_phys;
    logic              retire_regwrite;
    logic [31:0]       retire_pc;
    logic [TAG_W:0]    count;
    logic              empty;

    reorder_buffer #(.DEPTH(DEPTH), .TAG_W(TAG_W), .PHYS_W(PHYS_W)) dut (
        .CLK            (CLK),
        .RESET          (RESET),
        .flush          (flush),
        .alloc_valid    (alloc_valid),
        .alloc_arch_dst (alloc_arch_dst),
        .alloc_new_phys (alloc_new_phys),
        .alloc_old_phys (alloc_old_phys),
        .alloc_regwrite (alloc_regwrite),
        .alloc_pc       (alloc_pc),
        .alloc_ready    (alloc_ready),
        .alloc_tag      (alloc_tag),
        .cmpl_exe_valid (cmpl_exe_valid),
        .cmpl_exe_tag   (cmpl_exe_tag),
        .cmpl_mem_valid (cmpl_mem_valid),
        .cmpl_mem_tag   (cmpl_mem_tag),
        .retire_valid   (retire_valid),
        .retire_arch_dst(retire_arch_dst),
        .retire_new_phys(retire_new_phys),
        .retire_old_phys(retire_old_phys),
        .retire_regwrite(retire_regwrite),
        .retire_pc      (retire_pc),
        .count          (count),
        .empty          (empty)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        int          tag;
        logic [4:0]  arch;
        logic [5:0]  np;
        logic [5:0]  op;
        logic        rw;
        logic [31:0] pc;
        bit          done;
    } ent_t;

    ent_t        mq[$];
    int          next_tag;
    logic        e_rv;
    logic [4:0]  e_arch;
    logic [5:0]  e_np;
    logic [5:0]  e_op;
    logic        e_rw;
    logic [31:0] e_pc;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", name, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        next_tag = 0;
        e_rv = 1'b0; e_arch = '0; e_np = '0; e_op = '0; e_rw = 1'b0; e_pc = '0;
    endtask

    task automatic model_mark(input int t);
        foreach (mq[i]) if (mq[i].tag == t) mq[i].done = 1'b1;
    endtask

    task automatic chk_front(input string pfx);
        chk({pfx, "_alloc_ready"}, 64'(alloc_ready), 64'(mq.size() < DEPTH));
        chk({pfx, "_alloc_tag"},   64'(alloc_tag),   64'(next_tag));
        chk({pfx, "_empty"},       64'(empty),       64'(mq.size() == 0));
        chk({pfx, "_count"},       64'(count),       64'(mq.size()));
    endtask

    task automatic chk_retire(input string pfx);
        chk({pfx, "_retire_valid"}, 64'(retire_valid),    64'(e_rv));
        chk({pfx, "_retire_arch"},  64'(retire_arch_dst), 64'(e_arch));
        chk({pfx, "_retire_new"},   64'(retire_new_phys), 64'(e_np));
        chk({pfx, "_retire_old"},   64'(retire_old_phys), 64'(e_op));
        chk({pfx, "_retire_rw"},    64'(retire_regwrite), 64'(e_rw));
        chk({pfx, "_retire_pc"},    64'(retire_pc),       64'(e_pc));
    endtask

    // One clock: drive at negedge, check pre-edge view, advance model, check post-edge.
    task automatic step(input logic av, input logic [4:0] arch, input logic [5:0] np,
                        input logic [5:0] op, input logic rw, input logic [31:0] pc,
                        input logic ev, input int et, input logic mv, input int mt,
                        input logic fl);
        bit   rdy;
        bit   do_ret;
        ent_t e;
        @(negedge CLK);
        alloc_valid = av; alloc_arch_dst = arch; alloc_new_phys = np; alloc_old_phys = op;
        alloc_regwrite = rw; alloc_pc = pc;
        cmpl_exe_valid = ev; cmpl_exe_tag = TAG_W'(et);
        cmpl_mem_valid = mv; cmpl_mem_tag = TAG_W'(mt);
        flush = fl;
        #1;
        chk_front("pre");
        if (fl) begin
            mq.delete();
            next_tag = 0;
            e_rv = 1'b0;
        end else begin
            rdy    = (mq.size() < DEPTH);
            do_ret = (mq.size() > 0) && mq[0].done;
            if (ev) model_mark(et);
            if (mv) model_mark(mt);
            if (do_ret) begin
                e = mq.pop_front();
                e_rv = 1'b1; e_arch = e.arch; e_np = e.np; e_op = e.op;
                e_rw = e.rw && (e.arch != 5'd0); e_pc = e.pc;
            end else begin
                e_rv = 1'b0;
            end
            if (av && rdy) begin
                e.tag = next_tag; e.arch = arch; e.np = np; e.op = op;
                e.rw = rw; e.pc = pc; e.done = 1'b0;
                mq.push_back(e);
                next_tag = (next_tag + 1) % DEPTH;
            end
        end
        @(posedge CLK);
        #1;
        chk_retire("post");
        chk("post_count", 64'(count), 64'(mq.size()));
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic alloc(input logic [4:0] arch, input logic [5:0] np, input logic [5:0] op,
                         input logic rw);
        step(1, arch, np, op, rw, 32'h1000 + 32'(arch) * 4, 0, 0, 0, 0, 0);
    endtask

    task automatic cmpl_exe(input int t);
        step(0, 0, 0, 0, 0, 0, 1, t, 0, 0, 0);
    endtask

    task automatic do_flush();
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    endtask

    task automatic async_reset();
        @(negedge CLK);
        alloc_valid = 0; cmpl_exe_valid = 0; cmpl_mem_valid = 0; flush = 0;
        #2;
        RESET = 1'b0;
        #1;
        model_reset();
        chk_front("rst");
        chk_retire("rst");
        @(negedge CLK);
        RESET = 1'b1;
    endtask

    initial begin
        RESET = 1'b0;
        flush = 0; alloc_valid = 0; alloc_arch_dst = 0; alloc_new_phys = 0; alloc_old_phys = 0;
        alloc_regwrite = 0; alloc_pc = 0;
        cmpl_exe_valid = 0; cmpl_exe_tag = 0; cmpl_mem_valid = 0; cmpl_mem_tag = 0;
        model_reset();
        repeat (2) @(negedge CLK);
        chk_front("init");
        chk_retire("init");
        RESET = 1'b1;
        idle();

        // Out-of-order completion, in-order retirement.
        alloc(3, 33, 3, 1);
        alloc(4, 34, 4, 1);
        alloc(5, 35, 5, 1);
        cmpl_exe(2);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        cmpl_exe(1);
        repeat (3) idle();

        // Fill, blocked 17th alloc, retire from full, wrap of the tail.
        do_flush();
        for (int i = 0; i < DEPTH; i++) alloc(5'(i + 1), 6'(i + 40), 6'(i), 1);
        step(1, 20, 1, 2, 1, 32'hdead, 0, 0, 0, 0, 0);
        step(1, 20, 1, 2, 1, 32'hdead, 1, 0, 0, 0, 0);
        step(1, 20, 1, 2, 1, 32'hdead, 0, 0, 0, 0, 0);
        step(1, 21, 3, 4, 1, 32'hbeef, 0, 0, 0, 0, 0);
        for (int i = 0; i < DEPTH; i++) cmpl_exe(i);
        repeat (DEPTH + 2) idle();

        // Alloc and retire in one cycle at count 7; dual same-cycle completion.
        do_flush();
        for (int i = 0; i < 7; i++) alloc(5'(i + 8), 6'(i + 20), 6'(i + 1), 1);
        cmpl_exe(0);
        alloc(30, 60, 61, 1);
        step(0, 0, 0, 0, 0, 0, 1, 3, 1, 4, 0);
        step(0, 0, 0, 0, 0, 0, 1, 1, 1, 2, 0);
        repeat (6) idle();

        // Flush with 6 live entries, 2 done, plus simultaneous alloc and completion.
        do_flush();
        for (int i = 0; i < 6; i++) alloc(5'(i + 2), 6'(i + 10), 6'(i + 50), 1);
        step(0, 0, 0, 0, 0, 0, 1, 2, 1, 3, 0);
        step(1, 9, 9, 9, 1, 32'h42, 1, 1, 1, 0, 1);
        repeat (2) idle();

        // arch_dst 0 still retires with regwrite suppressed; stray completion to tag 9.
        alloc(0, 12, 13, 1);
        step(0, 0, 0, 0, 0, 0, 1, 0, 1, 9, 0);
        repeat (2) idle();
        for (int i = 0; i < 9; i++) alloc(5'(i + 1), 6'(i), 6'(i + 1), 1);
        repeat (3) idle();
        for (int i = 1; i < 10; i++) cmpl_exe(i);
        repeat (DEPTH) idle();

        // Async reset mid-run with 5 live entries.
        for (int i = 0; i < 5; i++) alloc(5'(i + 1), 6'(i), 6'(i), 1);
        cmpl_exe(2);
        async_reset();
        idle();
        alloc(7, 7, 7, 1);
        cmpl_exe(0);
        repeat (2) idle();

        // Random traffic.
        for (int c = 0; c < 1500; c++) begin
            int   et, mt;
            logic av, ev, mv, fl;
            if (mq.size() > 0 && $urandom_range(0, 3) != 0) et = mq[$urandom_range(0, mq.size() - 1)].tag;
            else et = int'($urandom_range(0, DEPTH - 1));
            if (mq.size() > 0 && $urandom_range(0, 3) != 0) mt = mq[$urandom_range(0, mq.size() - 1)].tag;
            else mt = int'($urandom_range(0, DEPTH - 1));
            av = ($urandom_range(0, 9) < 6);
            ev = ($urandom_range(0, 1) == 1);
            mv = ($urandom_range(0, 2) == 0);
            fl = ($urandom_range(0, 79) == 0);
            step(av, 5'($urandom), 6'($urandom), 6'($urandom), 1'($urandom), $urandom,
                 ev, et, mv, mt, fl);
        end
        repeat (3) idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
